sdram_arbiter: RTL
==================

# sdram_arbiter

Two-port arbiter sharing the single SDRAM controller between the camera write path and the display read path. Accepts one burst request per port, chooses a winner (urgency first, then round-robin, with a write anti-starvation cap), issues one command to the controller and steers burst data between the controller and the granted port. Sits between the capture/display FIFOs and the SDRAM controller inside `top`, clocked by `sys_clk`.

## Interface
- `ADDR_W`, 24, burst start address width (bank 2 + row 13 + col 9)
- `DATA_W`, 16, SDRAM data width
- `BURST_LEN`, 8, words per burst; must be at least 1
- `MAX_CONSEC_RD`, 4, maximum consecutive read grants while `wr_req` is pending; must be at least 1

Ports:
- `sys_clk`  in  1  system clock, 50 MHz
- `rst`  in  1  asynchronous, active-high reset
- `wr_req`  in  1  camera write burst request, held until `wr_gnt`
- `wr_addr`  in  ADDR_W  write burst start address, stable while `wr_req` is high
- `wr_gnt`  out  1  one-cycle pulse: write command accepted by controller
- `wr_data_rd`  out  1  pop strobe to write FIFO, one word per pulse
- `wr_data`  in  DATA_W  write FIFO head word, valid in the cycle of `wr_data_rd`
- `rd_req`  in  1  display read burst request, held until `rd_gnt`
- `rd_addr`  in  ADDR_W  read burst start address
- `rd_urgent`  in  1  display FIFO below low-water mark
- `rd_gnt`  out  1  one-cycle pulse: read command accepted
- `rd_data`  out  DATA_W  read word to display FIFO
- `rd_valid`  out  1  `rd_data` valid
- `cmd_valid`  out  1  command to controller
- `cmd_ready`  in  1  controller accepts command
- `cmd_wr`  out  1  1 = write, 0 = read
- `cmd_addr`  out  ADDR_W  command start address
- `cmd_wdata_req`  in  1  controller pulls one write word
- `cmd_wdata`  out  DATA_W  write word to controller
- `cmd_rdata`  in  DATA_W  read word from controller
- `cmd_rvalid`  in  1  `cmd_rdata` valid
- `cmd_done`  in  1  one-cycle pulse: burst finished
- `err`  out  1  sticky: beat count did not equal BURST_LEN at `cmd_done`

## Operation
- States: IDLE, ISSUE, WRITE, READ.
- IDLE:
  - if any request is pending, register the winner, `cmd_wr` and `cmd_addr`, then go to ISSUE.
  - Winner priority:
    1. write, if `wr_req` and the consecutive-read counter equals MAX_CONSEC_RD;
    2. read, if `rd_req` and `rd_urgent`;
    3. if only one request is pending, that one;
    4. if both are pending, the port not served last.
- ISSUE:
  - `cmd_valid`=1 until the cycle in which `cmd_ready`=1.
  - In that cycle, pulse `wr_gnt` or `rd_gnt`, clear the beat counter, and go to WRITE or READ.
- WRITE:
  - `wr_data_rd` = `cmd_wdata_req`, combinational.
  - `cmd_wdata` = `wr_data`.
  - Beat counter increments on each `cmd_wdata_req`.
- READ:
  - `rd_data` = `cmd_rdata`.
  - `rd_valid` = `cmd_rvalid`.
  - Beat counter increments on each `cmd_rvalid`.
- WRITE/READ exit on `cmd_done`:
  - compare beat count, including a beat in the same cycle, against BURST_LEN; set `err` on mismatch;
  - update last-served;
  - go to IDLE.
- Consecutive-read counter:
  - increments on `rd_gnt` while `wr_req` is high;
  - clears on `wr_gnt`, or whenever `wr_req` is low;
  - saturates at MAX_CONSEC_RD.
- Strobes seen outside their state are ignored: `cmd_wdata_req` outside WRITE, `cmd_rvalid` outside READ, `cmd_done` outside WRITE/READ.
- Requests deasserted before grant are a protocol violation; behaviour is undefined.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - counters 0;
  - last-served = write, so the first tie goes to read;
  - `err` = 0. Only `rst` clears `err`.
- Reset asserted mid-burst: outputs drop to 0 immediately (asynchronous). The controller's own reset handles its side.
- Request to `cmd_valid`: 1 cycle (IDLE registers the winner, ISSUE drives it).
- Grant pulse: in the `cmd_ready` cycle, 0 cycles after acceptance.
- Data steering: combinational, zero added latency in both directions.
- After `cmd_done`: at least one cycle in IDLE before the next `cmd_valid`. Back-to-back bursts therefore have 2 cycles of command overhead.
- `cmd_addr` and `cmd_wr` are stable from ISSUE entry until the next IDLE decision.

## Structure
- Shared package/header `sdram_pkg`:
  - state encoding (IDLE/ISSUE/WRITE/READ);
  - port IDs PORT_WR=0, PORT_RD=1;
  - default ADDR_W, DATA_W, BURST_LEN. The SDRAM controller uses the same defaults.
- Sub-module `sdram_arb_pick`: combinational winner selection. Inputs: `wr_req`, `rd_req`, `rd_urgent`, last-served, starve flag. Output: winner, valid. The FSM, counters and datapath muxing stay in `sdram_arbiter`.

## Test plan
- Single write: `wr_req`, `wr_addr`=0x000100, controller ready after 3 cycles, 8 pulls, `cmd_done` → `cmd_wr`=1, one `wr_gnt` pulse, exactly 8 `wr_data_rd` pulses, `err`=0.
- Tie: `wr_req`=`rd_req`=1 after reset, no urgency → order read, write, read, write.
- Urgent read with write pending, `rd_urgent` held high, MAX_CONSEC_RD=4 → 4 read grants, then 1 write grant, then reads resume.
- Read data: READ with `cmd_rvalid` plus 8 words 0xA000..0xA007 → `rd_data`/`rd_valid` match in the same cycles; strays on `cmd_rvalid` while in WRITE produce no `rd_valid`.
- Short burst: `cmd_done` after 6 beats → `err`=1, held through subsequent normal bursts until `rst`.
- Reset mid-WRITE after 3 beats → all outputs 0 immediately; after release, a pending `rd_req` is served first.

Source files
------------

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM arbiter/controller types and default geometry
package sdram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } arb_state_t;

    localparam logic PORT_WR = 1'b0;
    localparam logic PORT_RD = 1'b1;

    localparam int SDRAM_ADDR_W    = 24;
    localparam int SDRAM_DATA_W    = 16;
    localparam int SDRAM_BURST_LEN = 8;

endpackage

// File: rtl/sdram_arb_pick.sv
// rtl/sdram_arb_pick.sv - combinational winner selection between write and read ports
module sdram_arb_pick
    import sdram_pkg::*;
(
    input  logic i_wr_req,
    input  logic i_rd_req,
    input  logic i_rd_urgent,
    input  logic i_last_served,
    input  logic i_starve,
    output logic o_winner,
    output logic o_valid
);

    always_comb begin
        o_valid  = i_wr_req | i_rd_req;
        o_winner = PORT_WR;
        // Starvation cap beats urgency so the camera path can never be locked out.
        if (i_wr_req && i_starve)
            o_winner = PORT_WR;
        else if (i_rd_req && i_rd_urgent)
            o_winner = PORT_RD;
        else if (i_wr_req && i_rd_req)
            o_winner = ~i_last_served;
        else if (i_rd_req)
            o_winner = PORT_RD;
        else
            o_winner = PORT_WR;
    end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port burst arbiter in front of the single SDRAM controller
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W        = SDRAM_ADDR_W,
    parameter int DATA_W        = SDRAM_DATA_W,
    parameter int BURST_LEN     = SDRAM_BURST_LEN,
    parameter int MAX_CONSEC_RD = 4
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_gnt,
    output logic              wr_data_rd,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_urgent,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_wdata_req,
    output logic [DATA_W-1:0] cmd_wdata,
    input  logic [DATA_W-1:0] cmd_rdata,
    input  logic              cmd_rvalid,
    input  logic              cmd_done,
    output logic              err
);

    localparam int BEAT_W = $clog2(BURST_LEN + 1) + 1;
    localparam int CNT_W  = $clog2(MAX_CONSEC_RD + 1);
    localparam logic [BEAT_W:0]  BURST_CMP = (BEAT_W + 1)'(BURST_LEN);
    localparam logic [CNT_W-1:0] RD_CAP    = CNT_W'(MAX_CONSEC_RD);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic                r_cmd_wr;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_last;
    logic [CNT_W-1:0]    r_rd_cnt;
    logic                r_err;
    logic                w_winner;
    logic                w_pick_valid;
    logic                w_beat_now;
    logic                w_done;
    logic [BEAT_W:0]     w_beat_total;

    sdram_arb_pick u_pick (
        .i_wr_req      (wr_req),
        .i_rd_req      (rd_req),
        .i_rd_urgent   (rd_urgent),
        .i_last_served (r_last),
        .i_starve      (r_rd_cnt == RD_CAP),
        .o_winner      (w_winner),
        .o_valid       (w_pick_valid)
    );

    assign cmd_wr       = r_cmd_wr;
    assign cmd_addr     = r_cmd_addr;
    assign err          = r_err;
    assign w_beat_total = {1'b0, r_beat} + {{BEAT_W{1'b0}}, w_beat_now};

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Data steering is gated by state so strobes outside their burst phase are dropped.
    always_comb begin
        w_state_next = r_state;
        cmd_valid    = 1'b0;
        wr_gnt       = 1'b0;
        rd_gnt       = 1'b0;
        wr_data_rd   = 1'b0;
        cmd_wdata    = '0;
        rd_data      = '0;
        rd_valid     = 1'b0;
        w_beat_now   = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid)
                    w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    wr_gnt       = r_cmd_wr;
                    rd_gnt       = ~r_cmd_wr;
                    w_state_next = r_cmd_wr ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                wr_data_rd = cmd_wdata_req;
                cmd_wdata  = wr_data;
                w_beat_now = cmd_wdata_req;
                if (cmd_done) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_READ: begin
                rd_data    = cmd_rdata;
                rd_valid   = cmd_rvalid;
                w_beat_now = cmd_rvalid;
                if (cmd_done) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_cmd_wr   <= 1'b0;
            r_cmd_addr <= '0;
            r_beat     <= '0;
            r_last     <= PORT_WR;
            r_rd_cnt   <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_pick_valid) begin
                r_cmd_wr   <= (w_winner == PORT_WR);
                r_cmd_addr <= (w_winner == PORT_WR) ? wr_addr : rd_addr;
            end
            // Saturating beat count keeps runaway bursts from aliasing back to BURST_LEN.
            if (r_state == ST_ISSUE && cmd_ready)
                r_beat <= '0;
            else if (w_beat_now && r_beat != '1)
                r_beat <= r_beat + 1'b1;
            if (w_done) begin
                if (w_beat_total != BURST_CMP)
                    r_err <= 1'b1;
                r_last <= r_cmd_wr ? PORT_WR : PORT_RD;
            end
            if (wr_gnt || !wr_req)
                r_rd_cnt <= '0;
            else if (rd_gnt && r_rd_cnt != RD_CAP)
                r_rd_cnt <= r_rd_cnt + 1'b1;
        end
    end

endmodule
